div_unit: RTL

- Sequential 32-bit signed/unsigned integer divider. It is the inverse counterpart of the combinational multiplier in the execute stage.
- Radix-2 restoring algorithm: one quotient bit per clock, with a start/ready handshake toward the EX-stage stall logic.
- Produces {remainder, quotient} on a 64-bit bus that maps to HI/LO, matching the multiplier's 64-bit result path.

---
 rtl/div_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Sequential radix-2 restoring divider, signed/unsigned, one quotient bit per clock.
// Result bus is {remainder, quotient}, matching the multiplier's HI/LO result path.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 div_sign,
    input  logic                 div_start_i,
    input  logic                 div_annul_i,
    input  logic [WIDTH-1:0]     div_op1,
    input  logic [WIDTH-1:0]     div_op2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] raw_op1;
    logic             qsign;
    logic             rsign;
    logic             divzero;

    logic [WIDTH-1:0] op1_mag_c;
    logic [WIDTH-1:0] op2_mag_c;
    logic [WIDTH:0]   trial_c;
    logic [WIDTH-1:0] rem_out_c;
    logic [WIDTH-1:0] quot_out_c;

    // Operand magnitudes, trial subtraction and sign fix-up of the final result
    always_comb begin
        op1_mag_c  = (div_sign && div_op1[WIDTH-1]) ? (~div_op1 + WIDTH'(1)) : div_op1;
        op2_mag_c  = (div_sign && div_op2[WIDTH-1]) ? (~div_op2 + WIDTH'(1)) : div_op2;
        trial_c    = {rem, quot[WIDTH-1]} - {1'b0, divisor};
        rem_out_c  = rsign ? (~rem + WIDTH'(1)) : rem;
        quot_out_c = qsign ? (~quot + WIDTH'(1)) : quot;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (div_start_i) begin
                    state_next = (div_op2 == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (div_annul_i) begin
                    state_next = IDLE;
                end else if (cnt == CW'(WIDTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            raw_op1 <= '0;
            qsign   <= 1'b0;
            rsign   <= 1'b0;
            divzero <= 1'b0;
            result  <= '0;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            ready_o <= (state == DONE) && !div_annul_i;
            busy_o  <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (div_start_i) begin
                        divisor <= op2_mag_c;
                        quot    <= op1_mag_c;
                        raw_op1 <= div_op1;
                        qsign   <= div_sign & (div_op1[WIDTH-1] ^ div_op2[WIDTH-1]);
                        rsign   <= div_sign & div_op1[WIDTH-1];
                        divzero <= (div_op2 == '0);
                        rem     <= '0;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    if (!div_annul_i) begin
                        // A negative trial keeps the shifted remainder, which is known to fit
                        if (!trial_c[WIDTH]) begin
                            rem  <= trial_c[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], 1'b1};
                        end else begin
                            rem  <= {rem[WIDTH-2:0], quot[WIDTH-1]};
                            quot <= {quot[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (!div_annul_i) begin
                        result <= divzero ? {raw_op1, {WIDTH{1'b1}}} : {rem_out_c, quot_out_c};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
